// File: rtl/palette_pkg.sv
// Shared palette constants, colour type and transparency-key helper.
package palette_pkg;

  localparam int unsigned PAL_IDX_W           = 4;
  localparam int unsigned PAL_RGB_W           = 12;
  localparam int unsigned PAL_TRANSPARENT_IDX = 0;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb12_t;

  function automatic logic is_transparent(input logic [PAL_IDX_W-1:0] idx);
    return idx == PAL_IDX_W'(PAL_TRANSPARENT_IDX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 (wrapping) for the
// first valid input and returns a one-hot grant plus its encoded ID.
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_valid,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_grant_c,
  output logic [ID_W-1:0] o_grant_id_c
);

  int unsigned w_pos;
  logic        w_found;

  // ptr < N, so a single conditional subtract implements the wrap.
  always_comb begin
    o_grant_c    = '0;
    o_grant_id_c = '0;
    w_found      = 1'b0;
    w_pos        = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_pos = 32'(i_ptr) + k;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      if (!w_found && i_valid[ID_W'(w_pos)]) begin
        w_found                 = 1'b1;
        o_grant_c[ID_W'(w_pos)] = 1'b1;
        o_grant_id_c            = ID_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/palette_arbiter.sv
// Round-robin sharing of one palette lookup among N_REQ pixel requesters,
// two-stage pipeline. Optional index-0 transparency via PALETTE_ARB_TRANSPARENT_EN.
module palette_arbiter
  import palette_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned IDX_W = PAL_IDX_W,
  parameter  int unsigned RGB_W = PAL_RGB_W,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_hold,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*IDX_W-1:0] i_req_index,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic [IDX_W-1:0]       o_pal_index,
  input  logic [RGB_W-1:0]       i_pal_rgb,
  output logic                   o_rsp_valid,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic [RGB_W-1:0]       o_rsp_rgb,
  output logic                   o_rsp_transparent
);

  logic [N_REQ-1:0] w_valid_gated;
  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_grant_id;
  logic             w_xfer;
  logic             w_transparent;
  logic [IDX_W-1:0] w_idx_arr [N_REQ];

  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_s1_valid;
  logic [ID_W-1:0]  r_s1_id;
  logic [IDX_W-1:0] r_pal_index;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [RGB_W-1:0] r_rsp_rgb;
  logic             r_rsp_transparent;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_idx_arr[g] = i_req_index[g*IDX_W +: IDX_W];
  end

  // Hold and reset both suppress new grants without touching the pipeline.
  assign w_valid_gated = i_req_valid & {N_REQ{~(i_hold | i_rst)}};

  rr_arbiter #(.N(N_REQ)) u_rr (
    .i_valid      (w_valid_gated),
    .i_ptr        (r_rr_ptr),
    .o_grant_c    (w_grant),
    .o_grant_id_c (w_grant_id)
  );

  assign w_xfer      = |w_grant;
  assign o_req_ready = w_grant;

`ifdef PALETTE_ARB_TRANSPARENT_EN
  assign w_transparent = r_s1_valid && is_transparent(PAL_IDX_W'(r_pal_index));
`else
  assign w_transparent = 1'b0;
`endif

  // Stage 1 captures the granted index; stage 2 captures the palette result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr          <= ID_W'(N_REQ - 1);
      r_s1_valid        <= 1'b0;
      r_s1_id           <= '0;
      r_pal_index       <= '0;
      r_rsp_valid       <= 1'b0;
      r_rsp_id          <= '0;
      r_rsp_rgb         <= '0;
      r_rsp_transparent <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_rr_ptr    <= w_grant_id;
        r_s1_id     <= w_grant_id;
        r_pal_index <= w_idx_arr[w_grant_id];
      end
      r_s1_valid        <= w_xfer;
      r_rsp_valid       <= r_s1_valid;
      r_rsp_id          <= r_s1_id;
      r_rsp_rgb         <= w_transparent ? '0 : i_pal_rgb;
      r_rsp_transparent <= w_transparent;
    end
  end

  assign o_pal_index       = r_pal_index;
  assign o_rsp_valid       = r_rsp_valid;
  assign o_rsp_id          = r_rsp_id;
  assign o_rsp_rgb         = r_rsp_rgb;
  assign o_rsp_transparent = r_rsp_transparent;

endmodule

// File: tb/tb_palette_arbiter.sv
// Directed self-checking bench for palette_arbiter (N_REQ=4) with a small
// combinational palette model driving pal_rgb.
module tb_palette_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_index = '0;
  logic [3:0]  req_ready;
  logic [3:0]  pal_index;
  logic [11:0] pal_rgb;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [11:0] rsp_rgb;
  logic        rsp_transparent;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] pal_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    return 12'hFFF;
      4'd3:    return 12'h9BE;
      default: return {idx, 4'hA, ~idx};
    endcase
  endfunction

  function automatic logic [3:0] rr_idx(input int i);
    case (i)
      0:       return 4'd1;
      1:       return 4'd2;
      2:       return 4'd4;
      default: return 4'd5;
    endcase
  endfunction

  assign pal_rgb = pal_entry(pal_index);

  palette_arbiter #(.N_REQ(4)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_hold            (hold),
    .i_req_valid       (req_valid),
    .i_req_index       (req_index),
    .o_req_ready       (req_ready),
    .o_pal_index       (pal_index),
    .i_pal_rgb         (pal_rgb),
    .o_rsp_valid       (rsp_valid),
    .o_rsp_id          (rsp_id),
    .o_rsp_rgb         (rsp_rgb),
    .o_rsp_transparent (rsp_transparent)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; hold = 1'b0; req_valid = 4'hF; req_index = 16'h5421;
    tick(); tick();
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (pal_index !== 4'h0) begin failures++; $display("FAIL reset_pal_index got=%h exp=0", pal_index); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_rgb !== 12'h000) begin failures++; $display("FAIL reset_rsp_rgb got=%h exp=000", rsp_rgb); end
    checks++; if (rsp_transparent !== 1'b0) begin failures++; $display("FAIL reset_transparent got=%b exp=0", rsp_transparent); end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    req_valid = 4'b0001; req_index = 16'h0003;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (pal_index !== 4'd3) begin failures++; $display("FAIL single_pal_index got=%h exp=3", pal_index); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_rsp got=%b exp=0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_rgb !== 12'h9BE) begin failures++; $display("FAIL single_rsp_rgb got=%h exp=9BE", rsp_rgb); end
    checks++; if (rsp_transparent !== 1'b0) begin failures++; $display("FAIL single_transparent got=%b exp=0", rsp_transparent); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_pulse got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_ready;
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'hF; req_index = {4'd5, 4'd4, 4'd2, 4'd1};
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_ready = 4'(1 << (c % 4));
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
      if (c >= 1) begin
        checks++; if (pal_index !== rr_idx((c - 1) % 4)) begin failures++; $display("FAIL rr_pal_index c=%0d got=%h exp=%h", c, pal_index, rr_idx((c - 1) % 4)); end
      end
      if (c >= 2) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4)) begin failures++; $display("FAIL rr_rsp c=%0d got=%b/%0d exp=1/%0d", c, rsp_valid, rsp_id, (c - 2) % 4); end
        checks++; if (rsp_rgb !== pal_entry(rr_idx((c - 2) % 4))) begin failures++; $display("FAIL rr_rgb c=%0d got=%h exp=%h", c, rsp_rgb, pal_entry(rr_idx((c - 2) % 4))); end
      end
      tick();
    end
    req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_two_requesters;
    logic [3:0] exp_ready;
    int g1 = 0;
    int g3 = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b0010; req_index = 16'h7000 | 16'h0070;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL two_setup got=%b exp=0010", req_ready); end
    tick();
    req_valid = 4'b1010;
    for (int c = 0; c < 20; c++) begin
      #1;
      exp_ready = (c % 2 == 0) ? 4'b1000 : 4'b0010;
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL two_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
      if (req_ready[1]) g1++;
      if (req_ready[3]) g3++;
      tick();
    end
    checks++; if (g1 !== 10) begin failures++; $display("FAIL two_starve1 got=%0d exp=10", g1); end
    checks++; if (g3 !== 10) begin failures++; $display("FAIL two_starve3 got=%0d exp=10", g3); end
    req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_hold;
    int pulses = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b0011; req_index = 16'h0062;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL hold_g0 got=%b exp=0001", req_ready); end
    tick();
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL hold_g1 got=%b exp=0010", req_ready); end
    tick();
    hold = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL hold_ready c=%0d got=%b exp=0000", c, req_ready); end
      if (rsp_valid) pulses++;
      tick();
    end
    checks++; if (pulses !== 2) begin failures++; $display("FAIL hold_pulses got=%0d exp=2", pulses); end
    hold = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL hold_release got=%b exp=0001", req_ready); end
    req_valid = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_midop;
    int pulses = 0;
    req_valid = 4'b0001; req_index = 16'h0005;
    tick();
    req_valid = '0;
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL midrst_ready got=%b exp=0000", req_ready); end
    tick();
    rst = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (pal_index !== 4'h0) begin failures++; $display("FAIL midrst_pal_index got=%h exp=0", pal_index); end
    checks++; if (rsp_id !== 2'd0 || rsp_rgb !== 12'h000 || rsp_transparent !== 1'b0) begin failures++; $display("FAIL midrst_outputs got=%0d/%h/%b exp=0/000/0", rsp_id, rsp_rgb, rsp_transparent); end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rsp_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL midrst_ghost got=%0d exp=0", pulses); end
  endtask

  task automatic test_index_zero;
    logic        exp_t;
    logic [11:0] exp_rgb;
`ifdef PALETTE_ARB_TRANSPARENT_EN
    exp_t = 1'b1; exp_rgb = 12'h000;
`else
    exp_t = 1'b0; exp_rgb = 12'hFFF;
`endif
    req_valid = 4'b0100; req_index = 16'h0000;
    tick();
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin failures++; $display("FAIL idx0_rsp got=%b/%0d exp=1/2", rsp_valid, rsp_id); end
    checks++; if (rsp_transparent !== exp_t) begin failures++; $display("FAIL idx0_transparent got=%b exp=%b", rsp_transparent, exp_t); end
    checks++; if (rsp_rgb !== exp_rgb) begin failures++; $display("FAIL idx0_rgb got=%h exp=%h", rsp_rgb, exp_rgb); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_two_requesters();
    test_hold();
    test_reset_midop();
    test_index_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/palette_arbiter.md
# palette_arbiter

Round-robin arbiter that shares a single 16-entry palette lookup between up to N_REQ pixel requesters (stage background, fighter sprites, HUD). It accepts at most one 4-bit colour index per cycle, drives the registered index to the palette, and returns the registered 12-bit RGB result tagged with the requester ID. It sits between the sprite/background fetch units and the VGA pixel mux.

## Interface
- N_REQ, 4, number of requesters (2..8)
- IDX_W, 4, palette index width
- RGB_W, 12, packed {red, green, blue} width, 4 bits per channel
- ID_W, $clog2(N_REQ), requester ID width
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- hold  in  1  when high, no new grants; in-flight lookups complete
- req_valid  in  N_REQ  per-requester index valid
- req_index  in  N_REQ×IDX_W  per-requester palette index
- req_ready  out  N_REQ  one-hot grant; transfer when valid&ready
- pal_index  out  IDX_W  index driven to the palette lookup
- pal_rgb  in  RGB_W  palette result, combinational from pal_index
- rsp_valid  out  1  response valid, one-cycle pulse per accepted request
- rsp_id  out  ID_W  requester that issued the response
- rsp_rgb  out  RGB_W  looked-up colour
- rsp_transparent  out  1  colour is transparent (see Configuration)

## Operation
- Grant logic: combinational from req_valid, hold and rr_ptr. Search starts at (rr_ptr+1) mod N_REQ and wraps; the first valid requester is granted. req_ready is all-zero when hold=1 or no valid request.
- rr_ptr: register; on a transfer it loads the granted ID, otherwise it holds. Reset value N_REQ-1, so requester 0 wins first.
- Stage 1 (registered): s1_valid, s1_id, pal_index ← granted request. pal_index holds its last value when idle.
- Stage 2 (registered): rsp_valid←s1_valid, rsp_id←s1_id, rsp_rgb←pal_rgb, rsp_transparent per Configuration.
- No response backpressure; consumers must sample rsp_* whenever rsp_valid=1.
- A requester must hold req_index stable while req_valid=1 and req_ready=0; a transfer consumes exactly one index.
- hold asserted mid-stream: grants stop the same cycle; stage 1/2 contents still emerge.
- Reset mid-operation: in-flight lookups are discarded, with no response for them.

## Timing
- Accept at cycle T → pal_index valid at T+1 → rsp_valid at T+2. Fixed latency of 2; throughput 1 per cycle.
- Responses return in grant order.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once every N_REQ cycles.
- Reset values:
  - req_ready = 0
  - pal_index = 0
  - rsp_valid = 0
  - rsp_id = 0
  - rsp_rgb = 0
  - rsp_transparent = 0
  - s1_valid = 0
  - rr_ptr = N_REQ-1
- Reset is sampled on the Clk edge only. req_ready is forced to 0 while Reset=1.

## Configuration
- PALETTE_ARB_TRANSPARENT_EN defined:
  - Index 0 is the transparency key.
  - The response has rsp_transparent=1 and rsp_rgb=0 regardless of pal_rgb.
  - Latency is unchanged.
- PALETTE_ARB_TRANSPARENT_EN undefined:
  - rsp_transparent is tied to 0.
  - Index 0 returns the palette entry like any other index.

## Structure
- Shared package palette_pkg:
  - PAL_IDX_W=4, PAL_RGB_W=12, PAL_TRANSPARENT_IDX=0
  - typedef rgb12_t as a packed struct {red, green, blue}, 4 bits each
- Sub-module rr_arbiter (N parameter): takes valid[N] and ptr, produces a one-hot grant plus the encoded grant ID. It is reusable for the sprite-fetch memory port.
- The palette itself stays outside this block and connects through pal_index/pal_rgb.

## Test plan
- Reset, then requester 0 alone with index 3, palette returning 0x9BE for index 3 → req_ready[0] high in T, pal_index=3 at T+1, rsp_valid=1, rsp_id=0, rsp_rgb=0x9BE at T+2.
- N_REQ=4, all four valid with indices 1,2,4,5 held → grants in order 0,1,2,3,0…; each ID is granted every 4 cycles; rsp_id follows the same order 2 cycles later.
- Requesters 1 and 3 valid, rr_ptr=1 → requester 3 granted first, then 1; neither is starved across 20 cycles.
- hold raised while two lookups are in flight → req_ready=0 immediately; exactly two more rsp_valid pulses, then none until hold falls.
- Reset asserted one cycle after an accept → no rsp_valid afterwards; all outputs at reset values the following cycle.
- With PALETTE_ARB_TRANSPARENT_EN, request index 0 with palette entry 0xFFF → rsp_transparent=1, rsp_rgb=0x000.
- Without PALETTE_ARB_TRANSPARENT_EN, the same request → rsp_transparent=0, rsp_rgb=0xFFF.
